param_stack: RTL and testbench

PARAM_STACK -- requirements
Module: param_stack

---
 rtl/stack_pkg.sv | 23 ++
 rtl/stack_regfile.sv | 42 ++++
 rtl/param_stack.sv | 136 +++++++++++++
 tb/tb_param_stack.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared constants and sizing helpers for the parameterised stack.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package stack_pkg;

    // Default geometry used when the stack is instantiated without overrides
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    // Occupancy counter width: must represent 0..depth inclusive
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Storage index width: must address 0..depth-1, never narrower than 1 bit
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int DEF_CW = cnt_width(DEF_DEPTH);
    localparam int DEF_AW = addr_width(DEF_DEPTH);

endpackage

// File: rtl/stack_regfile.sv
// Stack word storage: one synchronous write port, two combinational read ports (top and word below).
// Latency: write visible on the read ports the cycle after the write edge; reads are same-cycle.
// Backpressure: none; the caller decides when a write is legal.
module stack_regfile
    import stack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_top_addr,
    output logic [WIDTH-1:0] rd_top_data,
    input  logic [AW-1:0]    rd_below_addr,
    output logic [WIDTH-1:0] rd_below_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Range guards matter only for non-power-of-two depths, where an index can exceed DEPTH-1
    logic wr_in_range;
    logic top_in_range;
    logic below_in_range;

    assign wr_in_range    = (int'(wr_addr) < DEPTH);
    assign top_in_range   = (int'(rd_top_addr) < DEPTH);
    assign below_in_range = (int'(rd_below_addr) < DEPTH);

    // Storage is deliberately not reset: entries at or above the occupancy are never observed
    always_ff @(posedge clk) begin
        if (wr_en && wr_in_range) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_top_data   = top_in_range   ? mem[rd_top_addr]   : '0;
    assign rd_below_data = below_in_range ? mem[rd_below_addr] : '0;

endmodule

// File: rtl/param_stack.sv
// LIFO stack with registered peek (top), registered pop data and one-cycle status pulses.
// Latency: pop -> data_out/out_valid 1 cycle; push -> top 1 cycle; flags decode the registered count.
// Backpressure: none; a push when full or pop when empty is dropped and flagged with overflow/underflow.
module param_stack
    import stack_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AFULL_LVL = DEPTH - 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             data_in,
    output logic [WIDTH-1:0]             data_out,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             top,
    output logic [cnt_width(DEPTH)-1:0]  count,
    output logic                         empty,
    output logic                         full,
    output logic                         almost_full,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int CW = cnt_width(DEPTH);
    localparam int AW = addr_width(DEPTH);

    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_TWO = CW'(2);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF  = CW'(AFULL_LVL);

    // Operation decode
    logic do_grow;     // accepted push that adds a word (includes push+pop on empty)
    logic do_shrink;   // accepted pop that removes a word
    logic do_swap;     // push+pop on a non-empty stack: replace top in place
    logic rej_push;
    logic rej_pop;

    // Storage interface
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    top_addr;
    logic [AW-1:0]    below_addr;
    logic [WIDTH-1:0] rd_top;
    logic [WIDTH-1:0] rd_below;

    // Status flags come straight from the registered occupancy
    assign empty       = (count == '0);
    assign full        = (count == CNT_MAX);
    assign almost_full = (count >= CNT_AF);

    // Classify this cycle's request against the current occupancy
    always_comb begin
        do_grow   = 1'b0;
        do_shrink = 1'b0;
        do_swap   = 1'b0;
        rej_push  = 1'b0;
        rej_pop   = 1'b0;
        unique case ({push, pop})
            2'b10: begin
                do_grow  = ~full;
                rej_push = full;
            end
            2'b01: begin
                do_shrink = ~empty;
                rej_pop   = empty;
            end
            2'b11: begin
                // An empty stack has nothing to swap: the push lands, the pop is refused
                do_swap = ~empty;
                do_grow = empty;
                rej_pop = empty;
            end
            default: begin
            end
        endcase
    end

    // Top lives at count-1; the word that becomes top after a pop lives at count-2
    assign top_addr   = AW'(count - CNT_ONE);
    assign below_addr = AW'(count - CNT_TWO);

    // A swap overwrites the current top slot, a grow writes the first free slot.
    // Writes are suppressed while reset is held so an in-flight push leaves no trace.
    assign wr_en   = ~reset & (do_grow | do_swap);
    assign wr_addr = do_swap ? top_addr : AW'(count);

    stack_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_regfile (
        .clk           (clk),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (data_in),
        .rd_top_addr   (top_addr),
        .rd_top_data   (rd_top),
        .rd_below_addr (below_addr),
        .rd_below_data (rd_below)
    );

    // Occupancy, peek register, pop data register and the one-cycle status pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count     <= '0;
            data_out  <= '0;
            top       <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            overflow  <= rej_push;
            underflow <= rej_pop;
            if (do_grow) begin
                count <= count + CNT_ONE;
                top   <= data_in;
            end else if (do_swap) begin
                data_out  <= rd_top;
                out_valid <= 1'b1;
                top       <= data_in;
            end else if (do_shrink) begin
                data_out  <= rd_top;
                out_valid <= 1'b1;
                count     <= count - CNT_ONE;
                // Popping the last word leaves nothing to peek at
                top       <= (count == CNT_ONE) ? '0 : rd_below;
            end
        end
    end

endmodule

// File: tb/tb_param_stack.sv
// Scoreboard bench for param_stack: queue-based stack model, directed scenarios then random traffic.
// Latency: expectations are tagged with the clock edge they describe and checked on the following negedge.
// Backpressure: n/a.
module tb_param_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AFULL = 3;

    logic             clk;
    logic             reset;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             out_valid;
    logic [WIDTH-1:0] top;
    logic [2:0]       count;
    logic             empty;
    logic             full;
    logic             almost_full;
    logic             overflow;
    logic             underflow;

    param_stack #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AFULL_LVL (AFULL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .pop         (pop),
        .data_in     (data_in),
        .data_out    (data_out),
        .out_valid   (out_valid),
        .top         (top),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic       ov;
        logic [7:0] dout;
        logic [7:0] top;
        int         cnt;
        logic       emp;
        logic       ful;
        logic       af;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] pop_q[$];

    // Reference model: the stack is just a queue, back = top
    logic [7:0] stk[$];
    logic [7:0] m_dout = 8'h00;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clocked request: update the model, queue the expected post-edge state, run the edge
    task automatic step(input logic p, input logic q, input logic [7:0] d);
        exp_t e;
        push    = p;
        pop     = q;
        data_in = d;
        e.ov  = 1'b0;
        e.ovf = 1'b0;
        e.unf = 1'b0;
        if (p && q) begin
            if (stk.size() == 0) begin
                stk.push_back(d);
                e.unf = 1'b1;
            end else begin
                m_dout = stk[stk.size()-1];
                e.ov   = 1'b1;
                stk[stk.size()-1] = d;
            end
        end else if (p) begin
            if (stk.size() == DEPTH) e.ovf = 1'b1;
            else stk.push_back(d);
        end else if (q) begin
            if (stk.size() == 0) e.unf = 1'b1;
            else begin
                m_dout = stk.pop_back();
                e.ov   = 1'b1;
            end
        end
        if (e.ov) pop_q.push_back(m_dout);
        e.cyc  = cyc + 1;
        e.dout = m_dout;
        e.cnt  = stk.size();
        e.top  = (stk.size() > 0) ? stk[stk.size()-1] : 8'h00;
        e.emp  = (stk.size() == 0);
        e.ful  = (stk.size() == DEPTH);
        e.af   = (stk.size() >= AFULL);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    // Monitor: compare the state expected for the edge just taken, and match popped words in order
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                chk("out_valid",   32'(out_valid),   32'(e.ov));
                chk("data_out",    32'(data_out),    32'(e.dout));
                chk("top",         32'(top),         32'(e.top));
                chk("count",       32'(count),       32'(e.cnt));
                chk("empty",       32'(empty),       32'(e.emp));
                chk("full",        32'(full),        32'(e.ful));
                chk("almost_full", 32'(almost_full), 32'(e.af));
                chk("overflow",    32'(overflow),    32'(e.ovf));
                chk("underflow",   32'(underflow),   32'(e.unf));
            end
            if (out_valid === 1'b1) begin
                if (pop_q.size() == 0) chk("unexpected_out_valid", 32'(out_valid), 32'd0);
                else chk("popped_word", 32'(data_out), 32'(pop_q.pop_front()));
            end
        end
    end

    initial begin
        reset   = 1'b1;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = 8'h00;
        #3;
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_top",       32'(top),       32'd0);
        chk("rst_data_out",  32'(data_out),  32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_overflow",  32'(overflow),  32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        chk("rst_empty",     32'(empty),     32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single push then pop
        step(1'b1, 1'b0, 8'hA4);
        step(1'b0, 1'b1, 8'h00);

        // Fill, overflow, drain in LIFO order
        step(1'b1, 1'b0, 8'h11);
        step(1'b1, 1'b0, 8'h22);
        step(1'b1, 1'b0, 8'h33);
        step(1'b1, 1'b0, 8'h44);
        step(1'b1, 1'b0, 8'h55);
        repeat (4) step(1'b0, 1'b1, 8'h00);

        // Pop on empty keeps the last popped word
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // Push+pop swaps the top of a non-empty stack
        step(1'b1, 1'b0, 8'h11);
        step(1'b1, 1'b0, 8'hC2);
        step(1'b1, 1'b1, 8'h7E);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h00);

        // Push+pop on empty: push lands, pop refused
        step(1'b1, 1'b1, 8'h5A);
        step(1'b0, 1'b1, 8'h00);

        // Swap on a full stack
        repeat (4) step(1'b1, 1'b0, 8'($urandom_range(0, 255)));
        step(1'b1, 1'b1, 8'hB3);
        step(1'b0, 1'b0, 8'h00);

        // Asynchronous reset between edges with a push in flight
        step(1'b0, 1'b1, 8'h00);
        @(negedge clk);
        #1;
        reset   = 1'b1;
        push    = 1'b1;
        data_in = 8'hEE;
        #1;
        chk("async_rst_count",    32'(count),     32'd0);
        chk("async_rst_top",      32'(top),       32'd0);
        chk("async_rst_data_out", 32'(data_out),  32'd0);
        chk("async_rst_empty",    32'(empty),     32'd1);
        @(posedge clk);
        #1;
        chk("rst_held_push_dropped", 32'(count), 32'd0);
        reset = 1'b0;
        push  = 1'b0;
        stk.delete();
        m_dout = 8'h00;
        step(1'b1, 1'b0, 8'h9F);
        step(1'b0, 1'b1, 8'h00);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 7));
            if (r < 3)       step(1'b1, 1'b0, 8'($urandom_range(0, 255)));
            else if (r < 5)  step(1'b0, 1'b1, 8'($urandom_range(0, 255)));
            else if (r < 7)  step(1'b1, 1'b1, 8'($urandom_range(0, 255)));
            else             step(1'b0, 1'b0, 8'($urandom_range(0, 255)));
        end

        // Drain the scoreboard within a bounded number of cycles
        repeat (3) @(negedge clk);
        #1;
        chk("expect_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("pop_queue_drained",    32'(pop_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
